lcplc_sequencer: RTL and testbench
==================================

LCPLC_SEQUENCER -- requirements
Module: lcplc_sequencer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, sample width.
REQ-002 SHALL have parameter DIM_WIDTH, default 10, width of the row-length and rows-per-slice fields.
REQ-003 SHALL have parameter BAND_WIDTH, default 8, width of the band-count field.
REQ-004 SHALL have parameter BLOCK_WIDTH, default 16, width of the block-count field.
REQ-005 SHALL have ports: clk in 1 (system clock); rst in 1 (reset).
REQ-006 SHALL have ports: cfg_start in 1 (start pulse); cfg_row_len in DIM_WIDTH (samples per row); cfg_rows in DIM_WIDTH (rows per slice); cfg_bands in BAND_WIDTH (bands per block); cfg_blocks in BLOCK_WIDTH (blocks per image).
REQ-007 SHALL have ports: s_valid in 1, s_ready out 1, s_data in DATA_WIDTH (raw sample stream).
REQ-008 SHALL have ports: x_valid out 1, x_ready in 1, x_data out DATA_WIDTH, x_last_r out 1, x_last_s out 1, x_last_b out 1, x_last_i out 1 (stream to the coder).
REQ-009 SHALL have ports: busy out 1 (RUN active); done out 1 (image-complete pulse).
REQ-010 SHALL use one clock, clk; rst SHALL be asynchronous and active-high.

Function
REQ-011 SHALL implement FSM IDLE -> RUN -> DONE -> IDLE.
REQ-012 In IDLE, cfg_start=1 with all cfg fields nonzero SHALL latch all cfg fields, clear all counters and enter RUN on the next edge.
REQ-013 In IDLE, cfg_start with any cfg field zero SHALL be ignored, and the FSM SHALL stay in IDLE.
REQ-014 cfg_start SHALL be ignored in RUN and DONE; cfg inputs SHALL be ignored outside the start cycle.
REQ-015 In RUN, x_valid=s_valid, s_ready=x_ready and x_data=s_data, all combinational with zero latency.
REQ-016 Outside RUN, x_valid=0 and s_ready=0.
REQ-017 Beat order SHALL be block, then band, then row, then sample; counters SHALL be sample c, row r, band b, block k, all starting at 0.
REQ-018 x_last_r SHALL equal (c==row_len-1).
REQ-019 x_last_s SHALL equal x_last_r and (r==rows-1).
REQ-020 x_last_b SHALL equal x_last_s and (b==bands-1).
REQ-021 x_last_i SHALL equal x_last_b and (k==blocks-1).
REQ-022 Last flags SHALL be 0 whenever the FSM is not in RUN.
REQ-023 Counters SHALL advance only on a handshake (x_valid and x_ready).
REQ-024 On a handshake, c SHALL increment, or wrap to 0 when x_last_r; r SHALL increment on x_last_r, wrapping to 0 on x_last_s; b SHALL increment on x_last_s, wrapping to 0 on x_last_b; k SHALL increment on x_last_b.
REQ-025 A handshake with x_last_i SHALL move the FSM to DONE.
REQ-026 done SHALL be 1 for exactly one cycle, in DONE; DONE SHALL return to IDLE unconditionally.
REQ-027 busy SHALL be 1 iff the FSM is in RUN.
REQ-028 With all dimensions equal to 1, every beat SHALL assert all four last flags, and the image SHALL complete after 1 beat.
REQ-029 The image SHALL contain exactly row_len*rows*bands*blocks beats; no counter SHALL exceed its latched limit.

Reset
REQ-030 rst=1 SHALL force IDLE, zero all counters and latched cfg, and drive busy=0, done=0, s_ready=0, x_valid=0 and all last flags 0, regardless of clk.
REQ-031 Reset mid-image SHALL abandon the image; the next cfg_start SHALL begin at counters zero.

Configuration
REQ-032 Macro LCPLC_SEQUENCER_STATS_EN defined SHALL add output stat_beats (32 bits): handshakes in the current or last image, cleared on accepted start and on rst, saturating at 2^32-1, held after DONE.
REQ-033 Without LCPLC_SEQUENCER_STATS_EN, the stat_beats port and its counter SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-034 Test: row_len=4, rows=2, bands=3, blocks=2, s_valid=x_ready=1 -> 48 beats; last_r on beats 4,8,...; last_s every 8; last_b every 24; last_i only on beat 48; done on cycle after beat 48.
REQ-035 Test: all dims 1, 1 beat -> beat has r/s/b/i=1; done pulse; busy 1 for 1 cycle.
REQ-036 Test: x_ready random 50%, s_valid random 70%, dims 3/2/2/1 -> 12 beats; data order preserved; flags identical to the unstalled run; no beat dropped or duplicated.
REQ-037 Test: cfg_start with cfg_bands=0 -> stays IDLE, s_ready=0; cfg_start in RUN with new dims -> ignored, original 48-beat sequence intact.
REQ-038 Test: rst asserted asynchronously after beat 10 of 48 -> outputs zero immediately; restart -> first beat counted as beat 1 (c=0).
REQ-039 Test, with STATS_EN: after the 48-beat image -> stat_beats=48; after a new start -> 0.

Source files
------------

// File: rtl/lcplc_sequencer.sv
// Image-scan sequencer: gates a raw sample stream into the coder and tags each beat with
// row/slice/band/image-last flags. Define LCPLC_SEQUENCER_STATS_EN to add the stat_beats counter.
module lcplc_sequencer #(
  parameter int DATA_WIDTH  = 16,
  parameter int DIM_WIDTH   = 10,
  parameter int BAND_WIDTH  = 8,
  parameter int BLOCK_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cfg_start,
  input  logic [DIM_WIDTH-1:0]   cfg_row_len,
  input  logic [DIM_WIDTH-1:0]   cfg_rows,
  input  logic [BAND_WIDTH-1:0]  cfg_bands,
  input  logic [BLOCK_WIDTH-1:0] cfg_blocks,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [DATA_WIDTH-1:0]  s_data,
  output logic                   x_valid,
  input  logic                   x_ready,
  output logic [DATA_WIDTH-1:0]  x_data,
  output logic                   x_last_r,
  output logic                   x_last_s,
  output logic                   x_last_b,
  output logic                   x_last_i,
  output logic                   busy,
  output logic                   done
`ifdef LCPLC_SEQUENCER_STATS_EN
  ,output logic [31:0]           stat_beats
`endif
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [DIM_WIDTH-1:0]   DIM_ONE   = DIM_WIDTH'(1);
  localparam logic [BAND_WIDTH-1:0]  BAND_ONE  = BAND_WIDTH'(1);
  localparam logic [BLOCK_WIDTH-1:0] BLOCK_ONE = BLOCK_WIDTH'(1);

  logic [1:0]             state_q,   state_d;
  logic [DIM_WIDTH-1:0]   row_len_q, row_len_d;
  logic [DIM_WIDTH-1:0]   rows_q,    rows_d;
  logic [BAND_WIDTH-1:0]  bands_q,   bands_d;
  logic [BLOCK_WIDTH-1:0] blocks_q,  blocks_d;
  logic [DIM_WIDTH-1:0]   c_q, c_d;
  logic [DIM_WIDTH-1:0]   r_q, r_d;
  logic [BAND_WIDTH-1:0]  b_q, b_d;
  logic [BLOCK_WIDTH-1:0] k_q, k_d;

  logic run, hs, cfg_ok;
  logic last_r, last_s, last_b, last_i;

  assign run    = (state_q == RUN);
  assign cfg_ok = (|cfg_row_len) && (|cfg_rows) && (|cfg_bands) && (|cfg_blocks);

  assign x_valid = run & s_valid;
  assign s_ready = run & x_ready;
  assign x_data  = s_data;
  assign hs      = x_valid & x_ready;
  assign busy    = run;
  assign done    = (state_q == DONE);

  // Each flag nests inside the one before it, so an image-last beat is also band/slice/row-last.
  assign last_r = (c_q == row_len_q - DIM_ONE);
  assign last_s = last_r && (r_q == rows_q - DIM_ONE);
  assign last_b = last_s && (b_q == bands_q - BAND_ONE);
  assign last_i = last_b && (k_q == blocks_q - BLOCK_ONE);

  assign x_last_r = run & last_r;
  assign x_last_s = run & last_s;
  assign x_last_b = run & last_b;
  assign x_last_i = run & last_i;

  always_comb begin
    state_d   = state_q;
    row_len_d = row_len_q;
    rows_d    = rows_q;
    bands_d   = bands_q;
    blocks_d  = blocks_q;
    c_d       = c_q;
    r_d       = r_q;
    b_d       = b_q;
    k_d       = k_q;
    case (state_q)
      IDLE: begin
        if (cfg_start && cfg_ok) begin
          state_d   = RUN;
          row_len_d = cfg_row_len;
          rows_d    = cfg_rows;
          bands_d   = cfg_bands;
          blocks_d  = cfg_blocks;
          c_d       = '0;
          r_d       = '0;
          b_d       = '0;
          k_d       = '0;
        end
      end
      RUN: begin
        if (hs) begin
          c_d = last_r ? '0 : c_q + DIM_ONE;
          if (last_r) r_d = last_s ? '0 : r_q + DIM_ONE;
          if (last_s) b_d = last_b ? '0 : b_q + BAND_ONE;
          // k wraps on the final beat so it never rests beyond its limit.
          if (last_b) k_d = last_i ? '0 : k_q + BLOCK_ONE;
          if (last_i) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      row_len_q <= '0;
      rows_q    <= '0;
      bands_q   <= '0;
      blocks_q  <= '0;
      c_q       <= '0;
      r_q       <= '0;
      b_q       <= '0;
      k_q       <= '0;
    end else begin
      state_q   <= state_d;
      row_len_q <= row_len_d;
      rows_q    <= rows_d;
      bands_q   <= bands_d;
      blocks_q  <= blocks_d;
      c_q       <= c_d;
      r_q       <= r_d;
      b_q       <= b_d;
      k_q       <= k_d;
    end
  end

`ifdef LCPLC_SEQUENCER_STATS_EN
  logic [31:0] stat_q, stat_d;

  always_comb begin
    stat_d = stat_q;
    if (state_q == IDLE && cfg_start && cfg_ok) stat_d = '0;
    else if (hs && stat_q != 32'hFFFF_FFFF)     stat_d = stat_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stat_q <= '0;
    else     stat_q <= stat_d;
  end

  assign stat_beats = stat_q;
`endif

endmodule

// File: tb/tb_lcplc_sequencer.sv
// Self-checking bench for lcplc_sequencer: randomized handshakes checked against an
// index-arithmetic model of the block/band/row/sample scan order.
module tb_lcplc_sequencer;

  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_start;
  logic [9:0]    cfg_row_len;
  logic [9:0]    cfg_rows;
  logic [7:0]    cfg_bands;
  logic [15:0]   cfg_blocks;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;
  logic          x_valid;
  logic          x_ready;
  logic [DW-1:0] x_data;
  logic          x_last_r, x_last_s, x_last_b, x_last_i;
  logic          busy, done;
`ifdef LCPLC_SEQUENCER_STATS_EN
  logic [31:0]   stat_beats;
`endif

  int checks = 0;
  int errors = 0;

  lcplc_sequencer #(
    .DATA_WIDTH(DW), .DIM_WIDTH(10), .BAND_WIDTH(8), .BLOCK_WIDTH(16)
  ) dut (
    .clk(clk), .rst(rst),
    .cfg_start(cfg_start), .cfg_row_len(cfg_row_len), .cfg_rows(cfg_rows),
    .cfg_bands(cfg_bands), .cfg_blocks(cfg_blocks),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .x_valid(x_valid), .x_ready(x_ready), .x_data(x_data),
    .x_last_r(x_last_r), .x_last_s(x_last_s), .x_last_b(x_last_b), .x_last_i(x_last_i),
    .busy(busy), .done(done)
`ifdef LCPLC_SEQUENCER_STATS_EN
    ,.stat_beats(stat_beats)
`endif
  );

  always #5 clk = ~clk;

  // Expected {last_r,last_s,last_b,last_i} for 0-based beat n of an L x R x B x K image.
  function automatic logic [3:0] model_flags(input int n, input int L, input int R,
                                             input int B, input int K);
    logic lr, ls, lb, li;
    lr = ((n % L) == L - 1);
    ls = lr && (((n / L) % R) == R - 1);
    lb = ls && (((n / (L * R)) % B) == B - 1);
    li = lb && ((n / (L * R * B)) == K - 1);
    return {lr, ls, lb, li};
  endfunction

  function automatic logic [DW-1:0] model_data(input int n);
    return DW'(n * 13 + 16'h0A05);
  endfunction

  task automatic do_start(input int L, input int R, input int B, input int K);
    @(posedge clk); #1;
    cfg_row_len = 10'(L); cfg_rows = 10'(R); cfg_bands = 8'(B); cfg_blocks = 16'(K);
    cfg_start = 1'b1; s_valid = 1'b0; x_ready = 1'b0;
    @(posedge clk); #1;
    cfg_start = 1'b0;
    cfg_row_len = 10'($urandom); cfg_rows = 10'($urandom);
    cfg_bands = 8'($urandom); cfg_blocks = 16'($urandom);
  endtask

  // Runs one image; poke_at injects a cfg_start with other dims at that beat index,
  // stop_after >= 0 leaves the image unfinished after that many handshakes.
  task automatic run_image(input int L, input int R, input int B, input int K,
                           input int pv, input int pr, input int poke_at, input int stop_after);
    int total, n, cyc;
    logic hs;
    logic [3:0] exp_f, got_f;
    total = L * R * B * K;
    n = 0;
    cyc = 0;
    do_start(L, R, B, K);
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL busy_after_start: got %b want 1", busy);
    end
    while (n < total && cyc < 20000) begin
      s_valid = ($urandom_range(99) < pv);
      x_ready = ($urandom_range(99) < pr);
      s_data  = model_data(n);
      if (n == poke_at) begin
        cfg_start = 1'b1; cfg_row_len = 10'd1; cfg_rows = 10'd1; cfg_bands = 8'd1; cfg_blocks = 16'd1;
      end
      #1;
      exp_f = model_flags(n, L, R, B, K);
      got_f = {x_last_r, x_last_s, x_last_b, x_last_i};
      hs = s_valid && x_ready;
      checks++;
      if (x_valid !== s_valid || s_ready !== x_ready || x_data !== model_data(n) || got_f !== exp_f) begin
        errors++;
        $display("FAIL beat_%0d: got v=%b r=%b d=%h f=%b want v=%b r=%b d=%h f=%b",
                 n + 1, x_valid, s_ready, x_data, got_f, s_valid, x_ready, model_data(n), exp_f);
      end
      if (hs) $display("beat %0d/%0d data=%h flags(r,s,b,i)=%b", n + 1, total, x_data, got_f);
      @(posedge clk); #1;
      cfg_start = 1'b0;
      if (hs) n++;
      cyc++;
      if (stop_after >= 0 && n == stop_after) break;
    end
    if (stop_after < 0) begin
      checks++;
      if (n != total) begin
        errors++; $display("FAIL beat_count: got %0d want %0d (cycle budget)", n, total);
      end
      s_valid = 1'b1; x_ready = 1'b1;
      #1;
      checks++;
      if (done !== 1'b1 || busy !== 1'b0 || x_valid !== 1'b0 || s_ready !== 1'b0 || x_last_i !== 1'b0) begin
        errors++;
        $display("FAIL done_pulse: got done=%b busy=%b xv=%b sr=%b li=%b want 1 0 0 0 0",
                 done, busy, x_valid, s_ready, x_last_i);
      end
`ifdef LCPLC_SEQUENCER_STATS_EN
      checks++;
      if (stat_beats !== 32'(total)) begin
        errors++; $display("FAIL stat_beats_done: got %0d want %0d", stat_beats, total);
      end
`endif
      @(posedge clk); #2;
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || s_ready !== 1'b0) begin
        errors++; $display("FAIL back_to_idle: got done=%b busy=%b sr=%b want 0 0 0", done, busy, s_ready);
      end
`ifdef LCPLC_SEQUENCER_STATS_EN
      checks++;
      if (stat_beats !== 32'(total)) begin
        errors++; $display("FAIL stat_beats_held: got %0d want %0d", stat_beats, total);
      end
`endif
      s_valid = 1'b0; x_ready = 1'b0;
    end
  endtask

  task automatic check_quiet(input string name);
    checks++;
    if ({busy, done, s_ready, x_valid, x_last_r, x_last_s, x_last_b, x_last_i} !== 8'b0) begin
      errors++;
      $display("FAIL %s: got busy,done,sr,xv,lr,ls,lb,li=%b want 00000000", name,
               {busy, done, s_ready, x_valid, x_last_r, x_last_s, x_last_b, x_last_i});
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; s_valid = 1'b1; x_ready = 1'b1;
    #2;
    check_quiet("reset_state");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1 check_quiet("idle_after_reset");
    s_valid = 1'b0; x_ready = 1'b0;
  endtask

  task automatic test_full();
    run_image(4, 2, 3, 2, 100, 100, -1, -1);
  endtask

  task automatic test_unit();
    run_image(1, 1, 1, 1, 100, 100, -1, -1);
  endtask

  task automatic test_stall();
    run_image(3, 2, 2, 1, 70, 50, -1, -1);
  endtask

  task automatic test_bad_start();
    @(posedge clk); #1;
    cfg_row_len = 10'd4; cfg_rows = 10'd2; cfg_bands = 8'd0; cfg_blocks = 16'd2;
    cfg_start = 1'b1;
    @(posedge clk); #1;
    cfg_start = 1'b0; s_valid = 1'b1; x_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 check_quiet("zero_band_start_ignored");
      @(posedge clk); #1;
    end
    s_valid = 1'b0; x_ready = 1'b0;
  endtask

  task automatic test_start_in_run();
    run_image(4, 2, 3, 2, 100, 100, 5, -1);
  endtask

  task automatic test_async_reset();
    run_image(4, 2, 3, 2, 100, 100, -1, 10);
    s_valid = 1'b1; x_ready = 1'b1;
    #2 rst = 1'b1;
    #1 check_quiet("async_reset_mid_image");
    #1 rst = 1'b0;
    s_valid = 1'b0; x_ready = 1'b0;
    run_image(4, 2, 3, 2, 100, 100, -1, -1);
  endtask

  task automatic test_stats_restart();
`ifdef LCPLC_SEQUENCER_STATS_EN
    do_start(4, 2, 3, 2);
    checks++;
    if (stat_beats !== 32'd0) begin
      errors++; $display("FAIL stat_beats_restart: got %0d want 0", stat_beats);
    end
    rst = 1'b1;
    #1 rst = 1'b0;
`endif
  endtask

  initial begin
    cfg_start = 1'b0; cfg_row_len = '0; cfg_rows = '0; cfg_bands = '0; cfg_blocks = '0;
    s_valid = 1'b0; x_ready = 1'b0; s_data = '0; rst = 1'b0;
    test_reset();
    test_full();
    test_unit();
    test_stall();
    test_bad_start();
    test_start_in_run();
    test_async_reset();
    test_stats_restart();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
